csum_sched: RTL

//  Round-robin scheduler sharing one channel-sum (csum) engine among N_LANES requesters.

---
 rtl/csum_sched_pkg.sv | 13 +
 rtl/csum_sched_rr_arbiter.sv | 30 +++
 rtl/csum_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/csum_sched_pkg.sv
// rtl/csum_sched_pkg.sv - shared state encodings and constants for the csum scheduler
package csum_sched_pkg;

    typedef enum logic [1:0] {
        CSUM_S_IDLE  = 2'd0,
        CSUM_S_GRANT = 2'd1,
        CSUM_S_RUN   = 2'd2,
        CSUM_S_DRAIN = 2'd3
    } csum_state_t;

    localparam logic [15:0] CSUM_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/csum_sched_rr_arbiter.sv
// rtl/csum_sched_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
    parameter int N_LANES = 4,
    parameter int LANE_W  = 2
) (
    input  logic [N_LANES-1:0] req,
    input  logic [LANE_W-1:0]  last_grant,
    output logic [N_LANES-1:0] win,
    output logic [LANE_W-1:0]  win_idx
);

    logic              found;
    logic [LANE_W-1:0] idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_LANES; i++) begin
            idx = LANE_W'((int'(last_grant) + i) % N_LANES);
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/csum_sched.sv
// rtl/csum_sched.sv - round-robin scheduler sharing one csum engine among N_LANES lanes
// Optional engine watchdog enabled by defining CSUM_TIMEOUT_EN.
module csum_sched
    import csum_sched_pkg::*;
#(
    parameter int N_LANES        = 4,
    parameter int LANE_W         = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_LANES-1:0]    req,
    input  logic [8*N_LANES-1:0]  req_ksize,
    output logic [N_LANES-1:0]    gnt,
    output logic [LANE_W-1:0]     fifo_sel,
    output logic                  eng_start,
    output logic [7:0]            eng_ksize,
    output logic                  eng_abort,
    input  logic                  eng_done,
    input  logic [15:0]           eng_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           res_data,
    output logic [LANE_W-1:0]     res_tag,
    output logic                  res_err,
    output logic                  busy
);

    if (N_LANES < 2 || N_LANES > 8 || (1 << LANE_W) < N_LANES ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("csum_sched: unsupported parameter combination");
    end

    csum_state_t       state;
    logic [LANE_W-1:0] last_grant;
    logic [N_LANES-1:0] win;
    logic [LANE_W-1:0] win_idx;
    logic [7:0]        win_ksize;

    rr_arbiter #(.N_LANES(N_LANES), .LANE_W(LANE_W)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .win        (win),
        .win_idx    (win_idx)
    );

    always_comb begin
        win_ksize = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (win_idx == LANE_W'(i)) win_ksize = req_ksize[8*i +: 8];
        end
    end

`ifdef CSUM_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        expire;

    // Counts RUN cycles; expiry lands on the TIMEOUT_CYCLES-th RUN cycle.
    assign expire = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     tmo_cnt <= '0;
        else if (state == CSUM_S_GRANT) tmo_cnt <= '0;
        else if (state == CSUM_S_RUN)   tmo_cnt <= tmo_cnt + 16'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CSUM_S_IDLE;
            last_grant <= LANE_W'(N_LANES - 1);
            gnt        <= '0;
            fifo_sel   <= '0;
            eng_start  <= 1'b0;
            eng_ksize  <= '0;
            eng_abort  <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_tag    <= '0;
            res_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt       <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            case (state)
                CSUM_S_IDLE: begin
                    if (|req) begin
                        gnt        <= win;
                        fifo_sel   <= win_idx;
                        eng_ksize  <= win_ksize;
                        eng_start  <= (win_ksize != 8'd0);
                        last_grant <= win_idx;
                        busy       <= 1'b1;
                        state      <= CSUM_S_GRANT;
                    end
                end
                CSUM_S_GRANT: begin
                    // Empty kernel skips the engine and reports a zero sum.
                    if (eng_ksize == 8'd0) begin
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_tag   <= fifo_sel;
                        res_err   <= 1'b0;
                        state     <= CSUM_S_DRAIN;
                    end else begin
                        state <= CSUM_S_RUN;
                    end
                end
                CSUM_S_RUN: begin
                    if (eng_done) begin
                        res_valid <= 1'b1;
                        res_data  <= eng_result;
                        res_tag   <= fifo_sel;
                        res_err   <= 1'b0;
                        state     <= CSUM_S_DRAIN;
                    end
`ifdef CSUM_TIMEOUT_EN
                    else if (expire) begin
                        eng_abort <= 1'b1;
                        res_valid <= 1'b1;
                        res_data  <= CSUM_ERR_DATA;
                        res_tag   <= fifo_sel;
                        res_err   <= 1'b1;
                        state     <= CSUM_S_DRAIN;
                    end
`endif
                end
                CSUM_S_DRAIN: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= CSUM_S_IDLE;
                    end
                end
                default: state <= CSUM_S_IDLE;
            endcase
        end
    end

endmodule
